// File: rtl/serial_rx.sv
// Memory-mapped 8N1 UART receiver with 16x oversampling and a byte FIFO.
// DATA (addr[2]=0) pops the head byte; STATUS (addr[2]=1) reports FIFO/error state and clears sticky flags.
module serial_rx #(
   parameter int CLK_HZ     = 10_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rxd,
   input  logic        sel,
   input  logic        re,
   input  logic [31:0] addr,
   output logic [31:0] dout,
   output logic        rx_valid
);

   localparam int DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int CW      = AW + 1;

   // states: IDLE wait start edge | START mid-start check | DATA 8 bits LSB first | STOP stop check | BREAK wait line high
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state;
   logic            rx_s1;
   logic            rxs;
   logic [PW-1:0]   presc;
   logic            tick;
   logic            start_go;
   logic [3:0]      tick_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shreg;
   logic            stop_smp;
   logic            push;
   logic            pop;
   logic            clr;
   logic            wr_en;
   logic            empty;
   logic            full;
   logic            overrun;
   logic            frame_err;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [31:0]     count_w;
   logic [4:0]      cnt5;
   logic            unused_addr;

   assign unused_addr = ^{addr[31:3], addr[1:0]};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_s1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         rx_s1 <= rxd;
         rxs   <= rx_s1;
      end
   end

   assign start_go = (state == S_IDLE) && !rxs;
   assign tick     = (presc == PW'(DIV - 1));

   // Prescaler realigns on the start edge so tick 7 lands mid start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (start_go || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!rxs) begin
                  state    <= S_START;
                  tick_cnt <= '0;
               end
            end
            S_START: begin
               if (tick) begin
                  if (tick_cnt == 4'd7) begin
                     tick_cnt <= '0;
                     if (rxs) begin
                        state <= S_IDLE;
                     end else begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            S_DATA: begin
               if (tick) begin
                  if (tick_cnt == 4'd15) begin
                     tick_cnt <= '0;
                     shreg    <= {rxs, shreg[7:1]};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        state <= S_STOP;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            S_STOP: begin
               if (tick) begin
                  if (tick_cnt == 4'd15) begin
                     tick_cnt <= '0;
                     state    <= rxs ? S_IDLE : S_BREAK;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            S_BREAK: begin
               if (rxs) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign stop_smp = (state == S_STOP) && tick && (tick_cnt == 4'd15);
   assign push     = stop_smp && rxs;
   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign pop      = sel && re && !addr[2] && !empty;
   assign clr      = sel && re && addr[2];
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign wr_en    = push && (!full || pop);

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr] <= shreg;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_en && !pop) begin
            count <= count + CW'(1);
         end else if (!wr_en && pop) begin
            count <= count - CW'(1);
         end
         overrun   <= (push && full && !pop) || (overrun && !clr);
         frame_err <= (stop_smp && !rxs) || (frame_err && !clr);
      end
   end

   assign count_w  = 32'(count);
   assign cnt5     = (count_w >= 32'd31) ? 5'd31 : count_w[4:0];
   assign rx_valid = !empty;

   always_comb begin
      dout = '0;
      if (sel) begin
         if (addr[2]) begin
            dout = {19'b0, cnt5, 4'b0, frame_err, overrun, full, !empty};
         end else if (!empty) begin
            dout = {24'b0, mem[rd_ptr]};
         end
      end
   end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx at 10 MHz / 125 kBd (80 clocks per bit).
module tb_serial_rx;

   localparam int BIT = 80;
   localparam logic [31:0] A_DATA = 32'h0;
   localparam logic [31:0] A_STAT = 32'h4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        rxd   = 1'b1;
   logic        sel   = 1'b0;
   logic        re    = 1'b0;
   logic [31:0] addr  = '0;
   logic [31:0] dout;
   logic        rx_valid;

   int n_run  = 0;
   int n_fail = 0;

   serial_rx #(
      .CLK_HZ    (10_000_000),
      .BAUD      (125000),
      .FIFO_DEPTH(16)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .rxd     (rxd),
      .sel     (sel),
      .re      (re),
      .addr    (addr),
      .dout    (dout),
      .rx_valid(rx_valid)
   );

   always #50 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] st(input int cnt, input bit fe, input bit ov,
                                      input bit fu, input bit ne);
      logic [4:0] c5;
      c5 = cnt[4:0];
      return {19'b0, c5, 4'b0, fe, ov, fu, ne};
   endfunction

   // Called just after a negedge; leaves rxd at the stop level.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (BIT) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clock);
      end
      rxd = stop;
      repeat (BIT) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b1);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      sel  = 1'b1;
      re   = 1'b1;
      addr = a;
      #1 d = dout;
      @(negedge clock);
      sel = 1'b0;
      re  = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      sel  = 1'b1;
      re   = 1'b0;
      addr = a;
      #1 d = dout;
      sel = 1'b0;
   endtask

   initial begin
      logic [31:0] d;

      repeat (3) @(negedge clock);
      sel  = 1'b1;
      addr = A_STAT;
      #1;
      chk("rst_status", dout, 32'h0);
      chk("rst_valid", {31'b0, rx_valid}, 32'h0);
      sel = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("idle_status", d, 32'h0);

      // single byte
      send_byte(8'hA5);
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("t1_status_pre", d, st(1, 0, 0, 0, 1));
      chk("t1_valid", {31'b0, rx_valid}, 32'h1);
      rd(A_DATA, d);
      chk("t1_data", d, 32'h0000_00A5);
      chk("t1_valid_after", {31'b0, rx_valid}, 32'h0);
      peek(A_STAT, d);
      chk("t1_status_post", d, 32'h0);
      rd(A_DATA, d);
      chk("t1_pop_empty", d, 32'h0);
      peek(A_STAT, d);
      chk("t1_status_empty_pop", d, 32'h0);

      // start-bit glitch
      rxd = 1'b0;
      repeat (30) @(negedge clock);
      rxd = 1'b1;
      repeat (200) @(negedge clock);
      peek(A_STAT, d);
      chk("t2_glitch_status", d, 32'h0);
      send_byte(8'h81);
      repeat (5) @(negedge clock);
      rd(A_DATA, d);
      chk("t2_after_glitch", d, 32'h81);

      // overflow
      for (int i = 0; i < 17; i++) send_byte(8'(i));
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("t3_full_status", d, st(16, 0, 1, 1, 1));
      for (int i = 0; i < 16; i++) begin
         rd(A_DATA, d);
         chk("t3_order", d, 32'(i));
      end
      rd(A_STAT, d);
      chk("t3_status_clr_read", d, st(0, 0, 1, 0, 0));
      peek(A_STAT, d);
      chk("t3_status_cleared", d, 32'h0);

      // framing error then break
      send_frame(8'h55, 1'b0);
      peek(A_STAT, d);
      chk("t4_frame_err", d, st(0, 1, 0, 0, 0));
      repeat (2 * BIT) @(negedge clock);
      rxd = 1'b1;
      repeat (40) @(negedge clock);
      send_byte(8'h3C);
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("t4_status", d, st(1, 1, 0, 0, 1));
      rd(A_DATA, d);
      chk("t4_data", d, 32'h3C);
      rd(A_STAT, d);
      chk("t4_clr_read", d, st(0, 1, 0, 0, 0));
      peek(A_STAT, d);
      chk("t4_cleared", d, 32'h0);

      // pop coincident with push while full
      for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("t5_full", d, st(16, 0, 0, 1, 1));
      fork
         send_byte(8'h99);
         begin
            logic [31:0] dh;
            repeat (762) @(negedge clock);
            rd(A_DATA, dh);
            chk("t5_pop_head", dh, 32'h40);
         end
      join
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("t5_status", d, st(16, 0, 0, 1, 1));
      for (int i = 1; i < 16; i++) begin
         rd(A_DATA, d);
         chk("t5_order", d, 32'(8'h40 + i));
      end
      rd(A_DATA, d);
      chk("t5_tail", d, 32'h99);
      peek(A_STAT, d);
      chk("t5_empty", d, 32'h0);

      // reset mid-frame with a byte already buffered
      send_byte(8'h11);
      repeat (5) @(negedge clock);
      fork
         send_byte(8'h5A);
         begin
            repeat (300) @(negedge clock);
            reset = 1'b0;
            sel   = 1'b1;
            addr  = A_STAT;
            #1 chk("t6_rst_status", dout, 32'h0);
            addr  = A_DATA;
            #1 chk("t6_rst_data", dout, 32'h0);
            chk("t6_rst_valid", {31'b0, rx_valid}, 32'h0);
            sel = 1'b0;
         end
      join
      repeat (20) @(negedge clock);
      reset = 1'b1;
      repeat (20) @(negedge clock);
      send_byte(8'hC3);
      repeat (5) @(negedge clock);
      peek(A_STAT, d);
      chk("t6_status", d, st(1, 0, 0, 0, 1));
      rd(A_DATA, d);
      chk("t6_data", d, 32'hC3);
      chk("t6_valid_after", {31'b0, rx_valid}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
